pc_redirect_ctrl: RTL
=====================

// Module: pc_redirect_ctrl
// PURPOSE
//  Fetch-side consumer of the ID-stage branch decision. Owns the PC register and
//  applies sequential, taken-branch, jump and jr redirects. Also generates the
//  IF/ID flush and rides out instruction-memory back-pressure: a redirect that
//  cannot be applied immediately is held pending until imem_ready.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; must be word aligned
//  ADDR_W     32             PC / target width
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  pcsrc          in   2       00 seq, 01 branch, 10 jump, 11 jr (ID-stage decode)
//  branch_bool    in   1       branch resolved taken (beq/bne), valid when pcsrc==01
//  branch_target  in   ADDR_W  PC-relative branch target
//  jump_target    in   ADDR_W  j/jal target
//  jr_target      in   ADDR_W  register target for jr
//  stall          in   1       hazard unit freeze of IF and ID (load-use)
//  imem_ready     in   1       instruction memory accepts fetch at pc this cycle
//  pc             out  ADDR_W  current fetch address
//  pc_plus4       out  ADDR_W  pc + 4, modulo 2^ADDR_W
//  imem_req       out  1       fetch request, high whenever out of reset
//  ifid_flush     out  1       IF/ID loads a bubble at this clock edge
//  redirect_busy  out  1       redirect pending, state HOLD
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      pc=RESET_PC, state RUN, pending target cleared.
//      ifid_flush=0, redirect_busy=0, imem_req=0.
//    imem_req rises in the first cycle after reset release.
//  - advance = imem_ready & ~stall.
//  - redir = ~stall & ((pcsrc==01 & branch_bool) | pcsrc==10 | pcsrc==11).
//    When stall=1, ID operands are invalid and pcsrc/branch_bool are ignored.
//  - tgt = mux(pcsrc: 01 branch_target, 10 jump_target, 11 jr_target).
//    tgt[1:0] forced to 2'b00.
//  - FSM RUN:
//      redir & imem_ready   -> pc<=tgt, ifid_flush=1 this cycle, stay RUN.
//      redir & ~imem_ready  -> pend<=tgt, ifid_flush=0, -> HOLD.
//      ~redir & advance     -> pc<=pc_plus4.
//      otherwise            -> pc holds.
//  - FSM HOLD (redirect_busy=1):
//      pcsrc/branch_bool/stall are ignored; the ID stage cannot change.
//      imem_ready -> pc<=pend, ifid_flush=1, -> RUN.
//      else       -> hold pc and pend.
//  - Latency: a redirect evaluated in cycle N with imem_ready=1 gives pc==tgt in N+1.
//    Each imem_ready=0 cycle adds one cycle.
//  - ifid_flush is combinational from state and inputs and is at most one cycle per
//    redirect. It is never high while stall=1 in RUN.
//  - Wrap: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; no flag.
//  - A reset during HOLD discards the pending target; pc=RESET_PC.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//    Adds out br_eval_cnt[31:0] and br_taken_cnt[31:0], both 0 on reset.
//    br_eval_cnt increments on each RUN cycle with pcsrc==01 & ~stall.
//    br_taken_cnt increments when additionally branch_bool=1.
//    Both saturate at 32'hFFFF_FFFF.
//  BRANCH_STATS_EN undefined: the ports and counters do not exist; all other
//  behaviour is identical.
// TESTING
//  1 Reset RESET_PC=0, imem_ready=1, pcsrc=00 for 3 cycles -> pc 0,4,8,C; ifid_flush=0.
//  2 pc=0x20, pcsrc=01, branch_bool=1, branch_target=0x100, imem_ready=1
//    -> ifid_flush=1 one cycle; next pc=0x100.
//    Same with branch_bool=0 -> pc=0x24, no flush.
//  3 pcsrc=10, jump_target=0x40, stall=1 -> pc holds, no flush.
//    Release stall -> pc=0x40, flush pulse.
//  4 pcsrc=11, jr_target=0x203, imem_ready=0 for 2 cycles
//    -> redirect_busy=1 for 2 cycles, pc holds.
//    imem_ready=1 -> flush, pc=0x200, busy=0.
//  5 In HOLD, assert rst_n=0 mid-cycle -> pc=RESET_PC immediately, busy=0.
//    pc=0xFFFF_FFFC sequential -> 0.
//  6 BRANCH_STATS_EN: 5 branches evaluated, 3 taken, 1 stalled
//    -> br_eval_cnt=5, br_taken_cnt=3.
//    Preload 32'hFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential advance plus branch/jump/jr redirects, holding a redirect pending across imem back-pressure.
// Redirect lands in pc one cycle after acceptance; optional BRANCH_STATS_EN adds saturating branch evaluation/taken counters.
module pc_redirect_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pcsrc,
    input  logic              branch_bool,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              stall,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              imem_req,
    output logic              ifid_flush,
    output logic              redirect_busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       br_eval_cnt,
    output logic [31:0]       br_taken_cnt
`endif
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] tgt_raw, tgt;
    logic              req_q;
    logic              redir;
    logic              advance;

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign imem_req      = req_q;
    assign redirect_busy = (state_q == HOLD);
    assign advance       = imem_ready & ~stall;
    assign redir         = ~stall & (((pcsrc == 2'b01) & branch_bool) | pcsrc[1]);

    always_comb begin
        tgt_raw = jr_target;
        case (pcsrc)
            2'b01:   tgt_raw = branch_target;
            2'b10:   tgt_raw = jump_target;
            default: tgt_raw = jr_target;
        endcase
        tgt = {tgt_raw[ADDR_W-1:2], 2'b00};
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        ifid_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (redir && imem_ready) begin
                    pc_d       = tgt;
                    ifid_flush = rst_n;
                end else if (redir) begin
                    pend_d  = tgt;
                    state_d = HOLD;
                end else if (advance) begin
                    pc_d = pc_plus4;
                end
            end
            HOLD: begin
                // ID is frozen behind the pending redirect, so only imem_ready matters here.
                if (imem_ready) begin
                    pc_d       = pend_q;
                    ifid_flush = rst_n;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            req_q   <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    logic br_eval;
    assign br_eval = (state_q == RUN) & (pcsrc == 2'b01) & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_eval_cnt  <= '0;
            br_taken_cnt <= '0;
        end else begin
            if (br_eval && (br_eval_cnt != 32'hFFFF_FFFF))
                br_eval_cnt <= br_eval_cnt + 32'd1;
            if (br_eval && branch_bool && (br_taken_cnt != 32'hFFFF_FFFF))
                br_taken_cnt <= br_taken_cnt + 32'd1;
        end
    end
`endif

endmodule
